ritc_ctrl_frame_serializer: RTL and testbench

//  Parametrised serial control-frame generator for RITC bit/channel delay control.

---
 rtl/ritc_ctrl_frame_serializer.sv | 192 +++++++++++++++++++
 tb/tb_ritc_ctrl_frame_serializer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ritc_ctrl_frame_serializer.sv
// ---------------------------------------------------------------------------
// ritc_ctrl_frame_serializer
//
// Serial control-frame generator for RITC bit/channel delay control. Commands
// arrive over a valid/ready handshake. They are double-buffered by a one-entry
// pending register, so the next command can be queued while a frame is on the
// line. Each command is sent on ctrl_o as one frame, in this order:
//   start(1), bitslip, delay (MSB first), one-hot channel field (highest index
//   first), one-hot bit field (highest index first) [, even parity].
//
// Optional feature: define RITC_CTRL_PARITY_EN to append one even-parity bit
// over frame bits 1..L-2. The start bit is not included in the parity.
//
// Ports
//   clk_i            system clock, all logic on posedge
//   rst_i            synchronous reset, active high
//   cmd_valid_i      command present
//   cmd_ready_o      command can be accepted this cycle
//   cmd_bitslip_i    bitslip flag for the frame
//   cmd_delay_i      delay value [DELAY_BITS]
//   cmd_chan_addr_i  channel index [CHAN_ADDR_W]
//   cmd_bit_addr_i   bit index [BIT_ADDR_W], BCAST_ADDR selects all bits
//   ctrl_o           registered serial control output to RITC
//   busy_o           registered; frame or gap in progress, or command pending
//   done_o           registered one-cycle pulse alongside the last frame bit
// ---------------------------------------------------------------------------
module ritc_ctrl_frame_serializer #(
    parameter int DELAY_BITS    = 5,
    parameter int CHAN_SEL_BITS = 32,
    parameter int BIT_SEL_BITS  = 32,
    parameter int CHAN_ADDR_W   = 3,
    parameter int BIT_ADDR_W    = 4,
    parameter int BCAST_ADDR    = 13,
    parameter int GAP_CYCLES    = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic                   cmd_bitslip_i,
    input  logic [DELAY_BITS-1:0]  cmd_delay_i,
    input  logic [CHAN_ADDR_W-1:0] cmd_chan_addr_i,
    input  logic [BIT_ADDR_W-1:0]  cmd_bit_addr_i,
    output logic                   ctrl_o,
    output logic                   busy_o,
    output logic                   done_o
);

`ifdef RITC_CTRL_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    localparam int FRAME_LEN = 2 + DELAY_BITS + CHAN_SEL_BITS + BIT_SEL_BITS + PAR_BITS;
    localparam int CHAN_BASE = 2 + DELAY_BITS;
    localparam int BIT_BASE  = CHAN_BASE + CHAN_SEL_BITS;

    localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);
    localparam logic [7:0] GAP_LAST = 8'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    // Frame image with frame bit i at vector index i, so the shifter drains LSB first.
    function automatic logic [FRAME_LEN-1:0] build_frame(
        input logic                   bitslip,
        input logic [DELAY_BITS-1:0]  delay,
        input logic [CHAN_ADDR_W-1:0] chan,
        input logic [BIT_ADDR_W-1:0]  bsel
    );
        logic [FRAME_LEN-1:0] f;
        f    = '0;
        f[0] = 1'b1;
        f[1] = bitslip;
        for (int j = 0; j < DELAY_BITS; j++)
            f[2 + j] = delay[DELAY_BITS-1-j];
        // Out-of-range addresses never match any index, leaving the field all zero.
        for (int k = 0; k < CHAN_SEL_BITS; k++)
            f[CHAN_BASE + CHAN_SEL_BITS - 1 - k] = (int'(chan) == k);
        for (int k = 0; k < BIT_SEL_BITS; k++)
            f[BIT_BASE + BIT_SEL_BITS - 1 - k] = (int'(bsel) == k) || (int'(bsel) == BCAST_ADDR);
`ifdef RITC_CTRL_PARITY_EN
        f[FRAME_LEN-1] = ^f[FRAME_LEN-2:1];
`endif
        return f;
    endfunction

    logic [1:0]             state;
    logic [1:0]             state_n;
    logic [7:0]             bit_cnt;
    logic [7:0]             gap_cnt;
    logic [FRAME_LEN-1:0]   sreg;
    logic [FRAME_LEN-1:0]   frame_ld;

    logic                   pend_full;
    logic                   pend_full_n;
    logic                   pend_bitslip;
    logic [DELAY_BITS-1:0]  pend_delay;
    logic [CHAN_ADDR_W-1:0] pend_chan;
    logic [BIT_ADDR_W-1:0]  pend_bit;

    logic                   take;
    logic                   end_pt;
    logic                   load;
    logic                   pend_fill;

    // Ready is blocked during reset so no transfer can happen in that cycle.
    assign cmd_ready_o = !pend_full && !rst_i;

    // A pending command always wins over the input port, keeping commands in order.
    assign frame_ld = pend_full ? build_frame(pend_bitslip, pend_delay, pend_chan, pend_bit)
                                : build_frame(cmd_bitslip_i, cmd_delay_i, cmd_chan_addr_i, cmd_bit_addr_i);

    always_comb begin
        take    = cmd_valid_i && cmd_ready_o;
        end_pt  = 1'b0;
        state_n = state;
        // end_pt: a new frame may start on the next cycle.
        case (state)
            ST_IDLE:  end_pt = 1'b1;
            ST_SHIFT: end_pt = (bit_cnt == 8'd0) && (GAP_CYCLES == 0);
            ST_GAP:   end_pt = (gap_cnt == 8'd0);
            default:  end_pt = 1'b0;
        endcase
        load = end_pt && (pend_full || take);
        // An accepted command goes straight to the shifter only if it is the one being loaded.
        pend_fill   = take && !(load && !pend_full);
        pend_full_n = pend_fill || (pend_full && !load);

        if (load) begin
            state_n = ST_SHIFT;
        end else begin
            case (state)
                ST_SHIFT: if (bit_cnt == 8'd0) state_n = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                ST_GAP:   if (gap_cnt == 8'd0) state_n = ST_IDLE;
                default:  state_n = ST_IDLE;
            endcase
        end
    end

    // Control stage: state, counters and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            pend_full <= 1'b0;
            bit_cnt   <= 8'd0;
            gap_cnt   <= 8'd0;
            ctrl_o    <= 1'b0;
            done_o    <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            state     <= state_n;
            pend_full <= pend_full_n;
            busy_o    <= (state_n != ST_IDLE) || pend_full_n;
            ctrl_o    <= 1'b0;
            done_o    <= 1'b0;
            if (load) begin
                ctrl_o  <= frame_ld[0];
                bit_cnt <= LAST_IDX;
            end else if (state == ST_SHIFT) begin
                // bit_cnt counts bits still to send after the one now on ctrl_o.
                if (bit_cnt != 8'd0) begin
                    ctrl_o  <= sreg[0];
                    bit_cnt <= bit_cnt - 8'd1;
                    done_o  <= (bit_cnt == 8'd1);
                end else begin
                    gap_cnt <= GAP_LAST;
                end
            end else if (state == ST_GAP) begin
                if (gap_cnt != 8'd0)
                    gap_cnt <= gap_cnt - 8'd1;
            end
        end
    end

    // Data stage: shifter and pending payload, not reset.
    always_ff @(posedge clk_i) begin
        if (load)
            sreg <= frame_ld >> 1;
        else if (state == ST_SHIFT)
            sreg <= sreg >> 1;
        if (pend_fill) begin
            pend_bitslip <= cmd_bitslip_i;
            pend_delay   <= cmd_delay_i;
            pend_chan    <= cmd_chan_addr_i;
            pend_bit     <= cmd_bit_addr_i;
        end
    end

endmodule

// File: tb/tb_ritc_ctrl_frame_serializer.sv
module tb_ritc_ctrl_frame_serializer;

`ifdef RITC_CTRL_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int L  = 71 + PAR;   // default instance
    localparam int LS = 43 + PAR;   // CHAN_SEL_BITS=4 instance

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       a_valid, a_ready, a_bs, a_ctrl, a_busy, a_done;
    logic [4:0] a_dly;
    logic [2:0] a_ch;
    logic [3:0] a_bt;

    logic       b_valid, b_ready, b_bs, b_ctrl, b_busy, b_done;
    logic [4:0] b_dly;
    logic [2:0] b_ch;
    logic [3:0] b_bt;

    ritc_ctrl_frame_serializer u_dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(a_valid), .cmd_ready_o(a_ready),
        .cmd_bitslip_i(a_bs), .cmd_delay_i(a_dly),
        .cmd_chan_addr_i(a_ch), .cmd_bit_addr_i(a_bt),
        .ctrl_o(a_ctrl), .busy_o(a_busy), .done_o(a_done)
    );

    ritc_ctrl_frame_serializer #(.CHAN_SEL_BITS(4), .GAP_CYCLES(0)) u_small (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(b_valid), .cmd_ready_o(b_ready),
        .cmd_bitslip_i(b_bs), .cmd_delay_i(b_dly),
        .cmd_chan_addr_i(b_ch), .cmd_bit_addr_i(b_bt),
        .ctrl_o(b_ctrl), .busy_o(b_busy), .done_o(b_done)
    );

    typedef struct {
        logic       bs;
        logic [4:0] dly;
        logic [2:0] ch;
        logic [3:0] bt;
        int         ones;   // hand count of ones in the frame, start bit included, no parity
    } vec_t;

    vec_t vt[5];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected frame, computed position by position from the frame layout.
    function automatic logic [127:0] model_frame(input int cbits, input logic bs,
                                                 input logic [4:0] d, input logic [2:0] ch,
                                                 input logic [3:0] bt);
        logic [127:0] f;
        logic par;
        int bb, pb;
        bb  = 7 + cbits;
        pb  = bb + 32;
        f   = '0;
        par = 1'b0;
        for (int p = 0; p < pb; p++) begin
            if (p == 0)       f[p] = 1'b1;
            else if (p == 1)  f[p] = bs;
            else if (p < 7)   f[p] = d[6-p];
            else if (p < bb)  f[p] = (int'(ch) == bb - 1 - p);
            else              f[p] = (bt == 4'd13) || (int'(bt) == pb - 1 - p);
            if (p > 0) par ^= f[p];
        end
        if (PAR == 1) f[pb] = par;
        return f;
    endfunction

    function automatic int ones_adj(input int ones);
        return ones + ((PAR == 1) ? ((ones - 1) & 1) : 0);
    endfunction

    task automatic send_a(input vec_t v);
        chk("ready_before_accept", 128'(a_ready), 128'd1);
        a_valid = 1'b1;
        a_bs = v.bs; a_dly = v.dly; a_ch = v.ch; a_bt = v.bt;
        tick();
        a_valid = 1'b0;
    endtask

    task automatic cap_a(output logic [127:0] fr, output logic [127:0] dn);
        fr = '0;
        dn = '0;
        for (int i = 0; i < L; i++) begin
            fr[i] = a_ctrl;
            dn[i] = a_done;
            tick();
        end
    endtask

    logic [127:0] fr, dn, e;
    logic [127:0] frs[5];
    int t_done, t_start, bad_ready;
    logic found, seen_done, seen_ctrl;

    initial begin
        vt[0] = '{1'b0, 5'b10110, 3'd2, 4'd5,  6};
        vt[1] = '{1'b1, 5'b00000, 3'd0, 4'd13, 35};
        vt[2] = '{1'b1, 5'b11111, 3'd7, 4'd15, 9};
        vt[3] = '{1'b0, 5'b00001, 3'd5, 4'd0,  4};
        vt[4] = '{1'b0, 5'b00000, 3'd0, 4'd15, 3};

        rst = 1'b1;
        a_valid = 1'b0; a_bs = 1'b0; a_dly = '0; a_ch = '0; a_bt = '0;
        b_valid = 1'b0; b_bs = 1'b0; b_dly = '0; b_ch = '0; b_bt = '0;
        repeat (3) tick();
        chk("ready_in_reset", 128'(a_ready), 128'd0);
        rst = 1'b0;
        #1;
        chk("rst_ctrl", 128'(a_ctrl), 128'd0);
        chk("rst_done", 128'(a_done), 128'd0);
        chk("rst_busy", 128'(a_busy), 128'd0);
        chk("rst_ready", 128'(a_ready), 128'd1);
        chk("rst_ready_small", 128'(b_ready), 128'd1);

        // Table: single frames with gap and busy timing.
        for (int i = 0; i < 5; i++) begin
            send_a(vt[i]);
            chk("busy_at_start", 128'(a_busy), 128'd1);
            cap_a(fr, dn);
            frs[i] = fr;
            chk("frame", fr, model_frame(32, vt[i].bs, vt[i].dly, vt[i].ch, vt[i].bt));
            chk("frame_ones", 128'($countones(fr)), 128'(ones_adj(vt[i].ones)));
            chk("done_pos", dn, 128'b1 << (L - 1));
            for (int g = 0; g < 2; g++) begin
                chk("gap_ctrl", 128'(a_ctrl), 128'd0);
                chk("gap_busy", 128'(a_busy), 128'd1);
                tick();
            end
            chk("busy_low_after_gap", 128'(a_busy), 128'd0);
        end

        // Literal frames for the two documented vectors.
        e = '0;
        e[0] = 1'b1; e[2] = 1'b1; e[4] = 1'b1; e[5] = 1'b1; e[36] = 1'b1; e[65] = 1'b1;
        if (PAR == 1) e[71] = 1'b1;
        chk("spec_vec_chan2_bit5", frs[0], e);
        e = '0;
        e[0] = 1'b1; e[1] = 1'b1; e[38] = 1'b1;
        for (int p = 39; p <= 70; p++) e[p] = 1'b1;
        chk("spec_vec_bcast", frs[1], e);

        // Back-to-back commands with a 2-cycle gap.
        send_a(vt[0]);
        chk("ready_before_second", 128'(a_ready), 128'd1);
        a_valid = 1'b1;
        a_bs = vt[2].bs; a_dly = vt[2].dly; a_ch = vt[2].ch; a_bt = vt[2].bt;
        tick();
        a_valid = 1'b0;
        chk("ready_low_pending", 128'(a_ready), 128'd0);
        t_done = -1; t_start = -1; bad_ready = 0; found = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (a_done) t_done = c;
            if (t_done >= 0 && c > t_done && a_ctrl) begin
                found = 1'b1;
                t_start = c;
                break;
            end
            if (a_ready) bad_ready++;
            if (!a_busy) bad_ready++;
            tick();
        end
        chk("second_start_seen", 128'(found), 128'd1);
        chk("gap_between_frames", 128'(t_start - t_done), 128'd3);
        chk("ready_low_until_start", 128'(bad_ready), 128'd0);
        chk("ready_at_second_start", 128'(a_ready), 128'd1);
        cap_a(fr, dn);
        chk("second_frame", fr, model_frame(32, vt[2].bs, vt[2].dly, vt[2].ch, vt[2].bt));
        chk("second_done_pos", dn, 128'b1 << (L - 1));
        tick(); tick();
        chk("busy_low_after_b2b", 128'(a_busy), 128'd0);

        // Reset pulse at frame bit 20, with a command held valid during reset.
        send_a(vt[1]);
        repeat (20) tick();
        rst = 1'b1;
        a_valid = 1'b1;
        a_bs = vt[0].bs; a_dly = vt[0].dly; a_ch = vt[0].ch; a_bt = vt[0].bt;
        #1;
        chk("ready_forced_low_rst", 128'(a_ready), 128'd0);
        tick();
        chk("abort_ctrl", 128'(a_ctrl), 128'd0);
        chk("abort_busy", 128'(a_busy), 128'd0);
        rst = 1'b0;
        a_valid = 1'b0;
        #1;
        chk("abort_ready", 128'(a_ready), 128'd1);
        seen_done = 1'b0; seen_ctrl = 1'b0;
        for (int c = 0; c < 80; c++) begin
            seen_done |= a_done;
            seen_ctrl |= a_ctrl;
            tick();
        end
        chk("abort_no_done", 128'(seen_done), 128'd0);
        chk("abort_no_frame", 128'(seen_ctrl), 128'd0);

        // Small instance: out-of-range channel and back-to-back with no gap.
        chk("small_ready", 128'(b_ready), 128'd1);
        b_valid = 1'b1;
        b_bs = 1'b0; b_dly = 5'b00000; b_ch = 3'd7; b_bt = 4'd3;
        tick();
        b_valid = 1'b0;
        fr = '0; dn = '0;
        for (int i = 0; i < LS; i++) begin
            fr[i] = b_ctrl;
            dn[i] = b_done;
            if (i == 0) begin
                b_valid = 1'b1;
                b_bs = 1'b1; b_dly = 5'b00101; b_ch = 3'd1; b_bt = 4'd0;
            end
            tick();
            if (i == 0) b_valid = 1'b0;
        end
        chk("small_frame_chan7", fr, model_frame(4, 1'b0, 5'b00000, 3'd7, 4'd3));
        chk("small_ones", 128'($countones(fr)), 128'(ones_adj(2)));
        chk("small_done_pos", dn, 128'b1 << (LS - 1));
        chk("small_b2b_start", 128'(b_ctrl), 128'd1);
        fr = '0; dn = '0;
        for (int i = 0; i < LS; i++) begin
            fr[i] = b_ctrl;
            dn[i] = b_done;
            tick();
        end
        chk("small_frame2", fr, model_frame(4, 1'b1, 5'b00101, 3'd1, 4'd0));
        chk("small_done2_pos", dn, 128'b1 << (LS - 1));
        chk("small_idle_ctrl", 128'(b_ctrl), 128'd0);
        chk("small_busy_low", 128'(b_busy), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
